// File: rtl/duc_src_arb_pkg.sv
// -----------------------------------------------------------------------------
// duc_src_arb_pkg
// Shared definitions for the DUC source arbiter: FSM state encoding, the
// bit-field layout of the cfg0 control word, and a grant decode helper.
// -----------------------------------------------------------------------------
package duc_src_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      GAP    = 2'd3
   } state_e;

   // cfg0 layout: [0] enable, [1] fixed priority, [15:8] inter-packet gap
   localparam int CFG_W         = 32;
   localparam int CFG_EN_BIT    = 0;
   localparam int CFG_FIXED_BIT = 1;
   localparam int CFG_GAP_LSB   = 8;
   localparam int CFG_GAP_W     = 8;

   // One-hot grant for a given state; 2'b00 outside the grant states.
   function automatic logic [1:0] grant_of(input state_e s);
      case (s)
         GRANT0:  return 2'b01;
         GRANT1:  return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/duc_src_arb_if.sv
// -----------------------------------------------------------------------------
// duc_src_arb_if
// Streaming handshake bundle used on both arbiter inputs and the output toward
// the DUC bank core.
//   tdata  : DATA_W packed I/Q sample (master -> slave)
//   tvalid : beat valid                (master -> slave)
//   tlast  : last beat of a packet     (master -> slave)
//   tready : slave accepts the beat    (slave  -> master)
// -----------------------------------------------------------------------------
interface duc_src_arb_if #(
   parameter int DATA_W = 32
) ();
   import duc_src_arb_pkg::*;

   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/duc_src_arb.sv
// -----------------------------------------------------------------------------
// duc_src_arb
// Two-source packet arbiter in front of the DUC bank core. Source 0 carries
// baseband TX, source 1 a calibration/test tone. A granted source is passed
// straight through (zero-cycle) until its last beat; packets are never cut.
// An optional idle gap separates consecutive packets.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous, active-high reset
//   cfg0       : [0] enable, [1] fixed priority (1) / round robin (0),
//                [15:8] inter-packet gap in cycles
//   s0, s1     : source streams (slave side)
//   bw20_data  : stream into the DUC bank core (master side)
//   grant      : one-hot active grant, 2'b00 when none
//   pkt_cnt0/1 : completed packets per source, wrapping
// -----------------------------------------------------------------------------
module duc_src_arb
   import duc_src_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CFG_W-1:0]  cfg0,
   duc_src_arb_if.slave      s0,
   duc_src_arb_if.slave      s1,
   duc_src_arb_if.master     bw20_data,
   output logic [1:0]        grant,
   output logic [CNT_W-1:0]  pkt_cnt0,
   output logic [CNT_W-1:0]  pkt_cnt1
);

   state_e               state_q, state_d;
   logic [1:0]           grant_q, grant_d;
   logic [CFG_GAP_W-1:0] gap_q, gap_d;
   logic                 last_s1_q, last_s1_d;
   logic [CNT_W-1:0]     cnt0_q, cnt0_d;
   logic [CNT_W-1:0]     cnt1_q, cnt1_d;

   logic                 cfg_en;
   logic                 cfg_fixed;
   logic [CFG_GAP_W-1:0] cfg_gap;
   logic                 unused_cfg;
   logic                 pick1;
   logic                 last_beat0;
   logic                 last_beat1;
   logic [DATA_W-1:0]    mux_data;

   assign cfg_en     = cfg0[CFG_EN_BIT];
   assign cfg_fixed  = cfg0[CFG_FIXED_BIT];
   assign cfg_gap    = cfg0[CFG_GAP_LSB +: CFG_GAP_W];
   assign unused_cfg = ^{cfg0[CFG_W-1:CFG_GAP_LSB+CFG_GAP_W],
                         cfg0[CFG_GAP_LSB-1:CFG_FIXED_BIT+1]};

   // A beat completes a packet only when it is actually transferred;
   // tlast with tvalid low is ignored.
   assign last_beat0 = s0.tvalid & s0.tlast & bw20_data.tready;
   assign last_beat1 = s1.tvalid & s1.tlast & bw20_data.tready;

   // Contention: fixed mode always favours s0; round robin favours the
   // source that did not hold the last grant.
   always_comb begin
      pick1 = 1'b0;
      if (s0.tvalid && s1.tvalid) begin
         pick1 = !cfg_fixed && !last_s1_q;
      end else begin
         pick1 = s1.tvalid;
      end
   end

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      last_s1_d = last_s1_q;
      cnt0_d    = cnt0_q;
      cnt1_d    = cnt1_q;
      case (state_q)
         IDLE: begin
            if (cfg_en && (s0.tvalid || s1.tvalid)) begin
               state_d   = pick1 ? GRANT1 : GRANT0;
               last_s1_d = pick1;
            end
         end
         GRANT0: begin
            if (last_beat0) begin
               cnt0_d = cnt0_q + CNT_W'(1);
               // Gap length is captured here so later cfg0 writes cannot
               // stretch or shorten a gap already in progress.
               if (cfg_gap != '0) begin
                  state_d = GAP;
                  gap_d   = cfg_gap;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GRANT1: begin
            if (last_beat1) begin
               cnt1_d = cnt1_q + CNT_W'(1);
               if (cfg_gap != '0) begin
                  state_d = GAP;
                  gap_d   = cfg_gap;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GAP: begin
            if (gap_q <= CFG_GAP_W'(1)) begin
               state_d = IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q - CFG_GAP_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      grant_d = grant_of(state_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         grant_q   <= 2'b00;
         gap_q     <= '0;
         last_s1_q <= 1'b1;
         cnt0_q    <= '0;
         cnt1_q    <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gap_q     <= gap_d;
         last_s1_q <= last_s1_d;
         cnt0_q    <= cnt0_d;
         cnt1_q    <= cnt1_d;
      end
   end

   // Output mux decodes the registered state only, so an asynchronous reset
   // silences every stream output immediately.
   always_comb begin
      mux_data         = '0;
      bw20_data.tvalid = 1'b0;
      bw20_data.tlast  = 1'b0;
      s0.tready        = 1'b0;
      s1.tready        = 1'b0;
      case (state_q)
         GRANT0: begin
            mux_data         = s0.tdata;
            bw20_data.tvalid = s0.tvalid;
            bw20_data.tlast  = s0.tlast;
            s0.tready        = bw20_data.tready;
         end
         GRANT1: begin
            mux_data         = s1.tdata;
            bw20_data.tvalid = s1.tvalid;
            bw20_data.tlast  = s1.tlast;
            s1.tready        = bw20_data.tready;
         end
         default: begin
         end
      endcase
      bw20_data.tdata = mux_data;
   end

   assign grant    = grant_q;
   assign pkt_cnt0 = cnt0_q;
   assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_duc_src_arb.sv
// -----------------------------------------------------------------------------
// tb_duc_src_arb
// Scoreboard bench for duc_src_arb: source beats come from per-source queues,
// the expected output order is pushed when a scenario is set up, and every
// transferred output beat is popped and compared.
// -----------------------------------------------------------------------------
module tb_duc_src_arb;

   localparam int DW = 32;
   localparam int CW = 16;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   cfg0 = '0;
   logic [1:0]    grant;
   logic [CW-1:0] pkt_cnt0;
   logic [CW-1:0] pkt_cnt1;

   duc_src_arb_if #(.DATA_W(DW)) s0_if ();
   duc_src_arb_if #(.DATA_W(DW)) s1_if ();
   duc_src_arb_if #(.DATA_W(DW)) bw_if ();

   duc_src_arb #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg0      (cfg0),
      .s0        (s0_if),
      .s1        (s1_if),
      .bw20_data (bw_if),
      .grant     (grant),
      .pkt_cnt0  (pkt_cnt0),
      .pkt_cnt1  (pkt_cnt1)
   );

   always #5 clk = ~clk;

   beat_t         q0[$];
   beat_t         q1[$];
   logic [DW-1:0] exp_q[$];
   logic [1:0]    glog[$];
   logic [1:0]    gprev = 2'b00;
   logic          toggle = 1'b0;
   int            out_cnt = 0;
   int            viol = 0;
   int            n_checks = 0;
   int            n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_cfg(input logic en, input logic fixed, input logic [7:0] gap);
      return {16'h0000, gap, 6'b000000, fixed, en};
   endfunction

   task automatic push_pkt(input int src, input logic [DW-1:0] base, input int len);
      for (int i = 0; i < len; i++) begin
         beat_t b;
         b.d = base + DW'(i);
         b.l = (i == len - 1);
         if (src == 0) q0.push_back(b);
         else          q1.push_back(b);
      end
   endtask

   task automatic exp_pkt(input logic [DW-1:0] base, input int len);
      for (int i = 0; i < len; i++) exp_q.push_back(base + DW'(i));
   endtask

   task automatic drive_srcs();
      if (q0.size() > 0) begin
         s0_if.tvalid = 1'b1; s0_if.tdata = q0[0].d; s0_if.tlast = q0[0].l;
      end else begin
         s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0;
      end
      if (q1.size() > 0) begin
         s1_if.tvalid = 1'b1; s1_if.tdata = q1[0].d; s1_if.tlast = q1[0].l;
      end else begin
         s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
      end
   endtask

   // One clock: sample handshakes on the falling edge, advance sources after
   // the rising edge.
   task automatic cycle();
      logic h0, h1, ho;
      logic [DW-1:0] od;
      @(negedge clk);
      h0 = s0_if.tvalid & s0_if.tready;
      h1 = s1_if.tvalid & s1_if.tready;
      ho = bw_if.tvalid & bw_if.tready;
      od = bw_if.tdata;
      if ((grant == 2'b01 && s1_if.tready) || (grant == 2'b10 && s0_if.tready)) viol++;
      if (grant != gprev && grant != 2'b00) glog.push_back(grant);
      gprev = grant;
      if (ho) begin
         out_cnt++;
         chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) chk("beat_data", 64'(od), 64'(exp_q.pop_front()));
      end
      @(posedge clk);
      #1;
      if (h0) void'(q0.pop_front());
      if (h1) void'(q1.pop_front());
      if (toggle) bw_if.tready = ~bw_if.tready;
      drive_srcs();
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0 || grant != 2'b00) && n < budget) begin
         cycle();
         n++;
      end
      chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      q0.delete(); q1.delete(); exp_q.delete(); glog.delete();
      toggle = 1'b0;
      bw_if.tready = 1'b1;
      drive_srcs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      gprev = 2'b00;
      viol = 0;
   endtask

   initial begin
      logic [1:0] eg[4];
      int n;
      int base;
      s0_if.tvalid = 1'b0; s0_if.tdata = '0; s0_if.tlast = 1'b0;
      s1_if.tvalid = 1'b0; s1_if.tdata = '0; s1_if.tlast = 1'b0;
      bw_if.tready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_cnt0", 64'(pkt_cnt0), 64'd0);
      chk("rst_cnt1", 64'(pkt_cnt1), 64'd0);
      chk("rst_s0_tready", 64'(s0_if.tready), 64'd0);
      chk("rst_s1_tready", 64'(s1_if.tready), 64'd0);
      chk("rst_out_tvalid", 64'(bw_if.tvalid), 64'd0);
      chk("rst_out_tdata", 64'(bw_if.tdata), 64'd0);

      // Single source, 4-beat packet, no gap
      reset_dut();
      cfg0 = mk_cfg(1'b1, 1'b0, 8'd0);
      push_pkt(0, 32'd1, 4);
      exp_pkt(32'd1, 4);
      drive_srcs();
      chk("single_grant_before", 64'(grant), 64'd0);
      cycle();
      chk("single_grant_one_cycle", 64'(grant), 64'h1);
      drain("single", 30);
      chk("single_cnt0", 64'(pkt_cnt0), 64'd1);
      chk("single_idle_grant", 64'(grant), 64'd0);

      // Round-robin contention
      reset_dut();
      cfg0 = mk_cfg(1'b1, 1'b0, 8'd0);
      push_pkt(0, 32'h100, 2); push_pkt(0, 32'h110, 2);
      push_pkt(1, 32'h200, 2); push_pkt(1, 32'h210, 2);
      exp_pkt(32'h100, 2); exp_pkt(32'h200, 2); exp_pkt(32'h110, 2); exp_pkt(32'h210, 2);
      drive_srcs();
      drain("rr", 60);
      eg = '{2'b01, 2'b10, 2'b01, 2'b10};
      chk("rr_grant_count", 64'(glog.size()), 64'd4);
      for (int i = 0; i < 4 && i < glog.size(); i++) chk("rr_grant_seq", 64'(glog[i]), 64'(eg[i]));
      chk("rr_cnt0", 64'(pkt_cnt0), 64'd2);
      chk("rr_cnt1", 64'(pkt_cnt1), 64'd2);

      // Fixed priority contention
      reset_dut();
      cfg0 = mk_cfg(1'b1, 1'b1, 8'd0);
      push_pkt(0, 32'h100, 2); push_pkt(0, 32'h110, 2);
      push_pkt(1, 32'h200, 2); push_pkt(1, 32'h210, 2);
      exp_pkt(32'h100, 2); exp_pkt(32'h110, 2); exp_pkt(32'h200, 2); exp_pkt(32'h210, 2);
      drive_srcs();
      drain("fixed", 60);
      eg = '{2'b01, 2'b01, 2'b10, 2'b10};
      chk("fixed_grant_count", 64'(glog.size()), 64'd4);
      for (int i = 0; i < 4 && i < glog.size(); i++) chk("fixed_grant_seq", 64'(glog[i]), 64'(eg[i]));

      // Inter-packet gap of 5; cfg0 rewritten mid-gap must not alter it
      reset_dut();
      cfg0 = mk_cfg(1'b1, 1'b0, 8'd5);
      push_pkt(0, 32'h700, 2); push_pkt(0, 32'h710, 2);
      exp_pkt(32'h700, 2); exp_pkt(32'h710, 2);
      drive_srcs();
      n = 0;
      while (out_cnt < 0 || n < 0) n++;
      base = out_cnt;
      n = 0;
      while (out_cnt < base + 2 && n < 20) begin cycle(); n++; end
      cfg0 = mk_cfg(1'b1, 1'b0, 8'd1);
      n = 0;
      viol = 0;
      while (grant == 2'b00 && n < 50) begin
         if (s0_if.tready || s1_if.tready || bw_if.tvalid || bw_if.tdata != '0) viol++;
         cycle();
         n++;
      end
      // 5 gap cycles plus one IDLE arbitration cycle before the next grant
      chk("gap_zero_grant_cycles", 64'(n), 64'd6);
      chk("gap_outputs_quiet", 64'(viol), 64'd0);
      drain("gap", 40);
      chk("gap_cnt0", 64'(pkt_cnt0), 64'd2);

      // Backpressure toggling every cycle
      reset_dut();
      cfg0 = mk_cfg(1'b1, 1'b0, 8'd0);
      bw_if.tready = 1'b0;
      toggle = 1'b1;
      push_pkt(0, 32'h300, 6); push_pkt(1, 32'h380, 3);
      exp_pkt(32'h300, 6); exp_pkt(32'h380, 3);
      drive_srcs();
      drain("bp", 80);
      chk("bp_other_tready_low", 64'(viol), 64'd0);
      chk("bp_cnt0", 64'(pkt_cnt0), 64'd1);
      chk("bp_cnt1", 64'(pkt_cnt1), 64'd1);
      toggle = 1'b0;
      bw_if.tready = 1'b1;

      // Enable cleared at beat 2: packet completes, then no new grant
      reset_dut();
      cfg0 = mk_cfg(1'b1, 1'b0, 8'd0);
      push_pkt(0, 32'h400, 4); push_pkt(1, 32'h500, 2);
      exp_pkt(32'h400, 4);
      drive_srcs();
      base = out_cnt;
      n = 0;
      while (out_cnt < base + 2 && n < 20) begin cycle(); n++; end
      cfg0 = mk_cfg(1'b0, 1'b0, 8'd0);
      repeat (12) cycle();
      chk("en_tail_forwarded", 64'(exp_q.size()), 64'd0);
      chk("en_no_grant", 64'(grant), 64'd0);
      chk("en_cnt0", 64'(pkt_cnt0), 64'd1);
      chk("en_cnt1", 64'(pkt_cnt1), 64'd0);
      chk("en_s1_pending", 64'(q1.size()), 64'd2);
      cfg0 = mk_cfg(1'b1, 1'b0, 8'd0);
      exp_pkt(32'h500, 2);
      drain("en_resume", 30);
      chk("en_resume_cnt1", 64'(pkt_cnt1), 64'd1);

      // Asynchronous reset at beat 2 of a packet
      reset_dut();
      cfg0 = mk_cfg(1'b1, 1'b0, 8'd0);
      push_pkt(0, 32'h600, 1);
      exp_pkt(32'h600, 1);
      drive_srcs();
      drain("pre_rst", 20);
      chk("pre_rst_cnt0", 64'(pkt_cnt0), 64'd1);
      push_pkt(0, 32'h610, 4);
      exp_pkt(32'h610, 4);
      drive_srcs();
      base = out_cnt;
      n = 0;
      while (out_cnt < base + 2 && n < 20) begin cycle(); n++; end
      chk("arst_reached_beat2", 64'(out_cnt - base), 64'd2);
      chk("arst_mid_pkt_tvalid", 64'(bw_if.tvalid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_tvalid", 64'(bw_if.tvalid), 64'd0);
      chk("arst_out_tdata", 64'(bw_if.tdata), 64'd0);
      chk("arst_s0_tready", 64'(s0_if.tready), 64'd0);
      chk("arst_grant", 64'(grant), 64'd0);
      chk("arst_cnt0", 64'(pkt_cnt0), 64'd0);
      q0.delete();
      exp_q.delete();
      drive_srcs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      base = out_cnt;
      repeat (5) cycle();
      chk("arst_no_forward", 64'(out_cnt - base), 64'd0);
      chk("arst_post_grant", 64'(grant), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/duc_src_arb.md
DUC_SRC_ARB -- requirements
Module: duc_src_arb

Interface
REQ-001 Parameter DATA_W, default 32, sample width (I/Q packed) on all stream ports.
REQ-002 Parameter CNT_W, default 16, width of per-source packet counters.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg0  in  32  [0] enable, [1] fixed-priority (1) vs round-robin (0), [15:8] inter-packet gap in cycles, others ignored.
REQ-007 s0_tdata/s0_tvalid/s0_tlast/s0_tready  in/in/in/out  DATA_W/1/1/1  source 0 stream (baseband TX).
REQ-008 s1_tdata/s1_tvalid/s1_tlast/s1_tready  in/in/in/out  DATA_W/1/1/1  source 1 stream (calibration/test tone).
REQ-009 bw20_data_tdata/bw20_data_tvalid/bw20_data_tready  out/out/in  DATA_W/1/1  stream into the DUC bank core.
REQ-010 grant  out  2  one-hot active grant, 2'b00 when none.
REQ-011 pkt_cnt0/pkt_cnt1  out  CNT_W  completed-packet count per source.

Function
REQ-012 FSM states SHALL be IDLE, GRANT0, GRANT1, GAP.
REQ-013 IDLE: if enable=0 stay; else if exactly one sX_tvalid=1 go GRANTX next cycle; if both valid, pick per REQ-014.
REQ-014 Both valid: fixed-priority picks s0; round-robin picks the source not granted last (s0 after reset).
REQ-015 GRANTX: bw20_data_tdata=sX_tdata, bw20_data_tvalid=sX_tvalid, sX_tready=bw20_data_tready, combinationally (zero-cycle pass-through); the other source's tready SHALL be 0.
REQ-016 In IDLE and GAP all s*_tready=0 and bw20_data_tvalid=0; bw20_data_tdata SHALL be 0.
REQ-017 Grant SHALL be held until a beat with sX_tvalid & bw20_data_tready & sX_tlast; no preemption.
REQ-018 On that last beat: pkt_cntX increments (wraps 2^CNT_W-1 -> 0); gap value cfg0[15:8] is sampled; next state GAP if gap>0, else IDLE.
REQ-019 GAP lasts exactly the sampled number of cycles, then IDLE; cfg0 changes during GAP have no effect on its length.
REQ-020 enable deasserted mid-packet: current packet completes, then block stays in IDLE; no packet truncated.
REQ-021 Minimum spacing: last beat at cycle N, next grant's first beat no earlier than cycle N+2+gap.
REQ-022 grant SHALL be 2'b01 in GRANT0, 2'b10 in GRANT1, 2'b00 otherwise, registered with state.
REQ-023 bw20_data_tready low stalls the granted source without state change; tlast while tvalid=0 SHALL be ignored.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, grant 0, pkt_cnt0/1 0, gap counter 0, round-robin pointer to "s1 last", all tready/tvalid outputs 0.
REQ-025 Reset mid-packet drops the grant; remaining beats of that packet are not forwarded after reset release unless re-arbitrated as a new packet.

Structure
REQ-026 State encoding and cfg0 bit-field positions/widths SHALL live in a shared package duc_src_arb_pkg.
REQ-027 No sub-module; single module with FSM, gap counter, two packet counters and the output mux.

Verification
REQ-028 Single source: s0 sends 4-beat packet (tdata 1..4), tready=1, gap=0 -> grant=01 one cycle after tvalid, beats 1..4 forwarded, pkt_cnt0=1, IDLE.
REQ-029 Round-robin contention: both valid continuously, cfg0[1]=0 -> grants alternate 01,10,01,10; fixed mode cfg0[1]=1 -> always 01.
REQ-030 Gap: cfg0[15:8]=5 -> exactly 5 GAP cycles with all tready=0 between last beat and next IDLE.
REQ-031 Backpressure: bw20_data_tready toggles every cycle mid-packet -> no beat lost or duplicated, s1_tready stays 0 during GRANT0.
REQ-032 enable cleared at beat 2 of 4 -> beats 3,4 still forwarded, then no further grant while s1_tvalid=1.
REQ-033 Async rst asserted between clock edges at beat 2 -> outputs 0 before the next edge, pkt_cnt0=0, grant=00.
